router_sync_n: RTL and testbench
================================

ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of output channels (range 2..16).
REQ-002 SHALL have parameter ADDR_W, default 2, address field width; NUM_CH <= 2**ADDR_W.
REQ-003 SHALL have parameter TIMEOUT, default 30, consecutive unread-valid cycles before soft reset (range 2..2**CNT_W-1).
REQ-004 SHALL have parameter CNT_W, default 5, per-channel timeout counter width.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port detect_add  input  1  header-byte strobe; latch data_in as destination address.
REQ-008 SHALL have port data_in  input  ADDR_W  destination address field.
REQ-009 SHALL have port write_enb_reg  input  1  FSM write request for current packet.
REQ-010 SHALL have port read_enb  input  NUM_CH  per-channel downstream read strobes.
REQ-011 SHALL have port empty  input  NUM_CH  per-channel FIFO empty flags.
REQ-012 SHALL have port full  input  NUM_CH  per-channel FIFO full flags.
REQ-013 SHALL have port write_enb  output  NUM_CH  one-hot FIFO write enables.
REQ-014 SHALL have port fifo_full  output  1  full flag of selected channel.
REQ-015 SHALL have port vld_out  output  NUM_CH  per-channel data-valid.
REQ-016 SHALL have port soft_reset  output  NUM_CH  per-channel timeout flush pulse (registered).
REQ-017 SHALL have port addr_err  output  1  latched address >= NUM_CH (registered).

Function
REQ-018 SHALL latch data_in into addr_reg on each rising edge with detect_add=1; addr_reg holds otherwise.
REQ-019 SHALL set addr_err to (data_in >= NUM_CH) on each edge with detect_add=1; hold otherwise.
REQ-020 SHALL drive write_enb[i]=1 only when write_enb_reg=1, addr_err=0, addr_reg=i, soft_reset[i]=0, resetn=1; all other bits 0 (combinational from addr_reg, not data_in).
REQ-021 SHALL drive fifo_full = full[addr_reg] when addr_err=0; fifo_full=0 when addr_err=1 (invalid packets drain and are dropped).
REQ-022 SHALL drive vld_out[i] = ~empty[i], combinational, all channels independent.
REQ-023 SHALL, per channel i, on each edge with vld_out[i]=1 and read_enb[i]=0: if cnt[i]==TIMEOUT-1 then cnt[i]<=0 and soft_reset[i]<=1, else cnt[i]<=cnt[i]+1 and soft_reset[i]<=0.
REQ-024 SHALL, per channel i, on each edge with vld_out[i]=0 or read_enb[i]=1: cnt[i]<=0, soft_reset[i]<=0.
REQ-025 SHALL therefore assert soft_reset[i] for exactly one cycle, starting the cycle after the TIMEOUT-th consecutive qualifying edge; counting restarts from 0 afterwards.
REQ-026 SHALL give read_enb[i] priority over terminal count: read at count TIMEOUT-1 clears, no pulse.
REQ-027 SHALL run all channel counters concurrently; multiple soft_reset bits may assert in the same cycle.
REQ-028 SHALL let detect_add and write_enb_reg in the same cycle use the old addr_reg for write_enb that cycle; new address effective next cycle.
REQ-029 SHALL never assert more than one write_enb bit in any cycle.

Reset
REQ-030 SHALL, on a rising edge with resetn=0, set addr_reg=0, addr_err=0, all cnt=0, all soft_reset=0.
REQ-031 SHALL force write_enb=0 while resetn=0; fifo_full and vld_out follow REQ-021/022 with reset state.
REQ-032 SHALL abandon any in-progress count on reset; a full TIMEOUT qualifying edges are required after release.

Verification
REQ-033 Defaults: reset, detect_add=1 data_in=2, then write_enb_reg=1 -> write_enb=3'b100; full=3'b100 -> fifo_full=1; full=3'b011 -> fifo_full=0.
REQ-034 Defaults: detect_add=1 data_in=3 -> next cycle addr_err=1, write_enb=0 with write_enb_reg=1, fifo_full=0 with full=3'b111; then data_in=1 -> addr_err=0, write_enb=3'b010.
REQ-035 Defaults: empty[0]=0, read_enb[0]=0 held -> soft_reset[0]=1 exactly one cycle after 30th edge, 0 otherwise; soft_reset[1..2]=0.
REQ-036 Defaults: as REQ-035 but read_enb[0]=1 on edge 30 -> no pulse; pulse only after 30 further qualifying edges; channels 1 and 2 timing out together pulse in same cycle.
REQ-037 Defaults: resetn=0 for one edge at count 20 on channel 0 -> no pulse at edge 30; pulse after 30 edges post-release; write_enb=0 during reset.
REQ-038 NUM_CH=5, ADDR_W=3, TIMEOUT=4: data_in=4 -> write_enb=5'b10000; data_in=6 -> addr_err=1; empty[4]=0 unread -> soft_reset[4] after 4th edge, write_enb[4]=0 during pulse.

Source files
------------

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the packet destination, steers FIFO write enables,
// reports the selected channel's full flag and flushes channels whose data sits unread.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  localparam logic [ADDR_W:0]  NUM_CH_W = (ADDR_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_err_q, addr_err_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] soft_reset_q, soft_reset_d;
  logic              full_sel_s;

  // Header capture: an out-of-range address is still latched but flagged
  always_comb begin
    if (detect_add) begin
      addr_d     = data_in;
      addr_err_d = ({1'b0, data_in} >= NUM_CH_W);
    end else begin
      addr_d     = addr_q;
      addr_err_d = addr_err_q;
    end
  end

  // Per-channel unread-data timers; a read always wins over the terminal count
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (vld_out[i] && !read_enb[i]) begin
        if (cnt_q[i] == TERM_CNT) begin
          cnt_d[i]        = {CNT_W{1'b0}};
          soft_reset_d[i] = 1'b1;
        end else begin
          cnt_d[i]        = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
          soft_reset_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i]        = {CNT_W{1'b0}};
        soft_reset_d[i] = 1'b0;
      end
    end
  end

  // Write steering uses the registered address, so a same-cycle header takes effect next cycle
  always_comb begin
    write_enb  = {NUM_CH{1'b0}};
    full_sel_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        write_enb[i] = resetn & write_enb_reg & ~addr_err_q & ~soft_reset_q[i];
        full_sel_s   = full[i];
      end else begin
        write_enb[i] = 1'b0;
      end
    end
  end

  assign fifo_full  = full_sel_s & ~addr_err_q;
  assign vld_out    = ~empty;
  assign soft_reset = soft_reset_q;
  assign addr_err   = addr_err_q;

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q       <= {ADDR_W{1'b0}};
      addr_err_q   <= 1'b0;
      soft_reset_q <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      addr_q       <= addr_d;
      addr_err_q   <= addr_err_d;
      soft_reset_q <= soft_reset_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n: a default instance (3 channels, timeout 30)
// and a 5-channel instance with a short timeout.
module tb_router_sync_n;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Default-parameter instance
  logic       resetn, detect_add, write_enb_reg;
  logic [1:0] data_in;
  logic [2:0] read_enb, empty, full;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic       fifo_full, addr_err;

  // NUM_CH=5, ADDR_W=3, TIMEOUT=4 instance
  logic       d2_resetn, d2_detect_add, d2_write_enb_reg;
  logic [2:0] d2_data_in;
  logic [4:0] d2_read_enb, d2_empty, d2_full;
  logic [4:0] d2_write_enb, d2_vld_out, d2_soft_reset;
  logic       d2_fifo_full, d2_addr_err;

  router_sync_n dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
    .write_enb(write_enb), .fifo_full(fifo_full), .vld_out(vld_out),
    .soft_reset(soft_reset), .addr_err(addr_err)
  );

  router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(4), .CNT_W(5)) dut2 (
    .clock(clock), .resetn(d2_resetn), .detect_add(d2_detect_add), .data_in(d2_data_in),
    .write_enb_reg(d2_write_enb_reg), .read_enb(d2_read_enb), .empty(d2_empty), .full(d2_full),
    .write_enb(d2_write_enb), .fifo_full(d2_fifo_full), .vld_out(d2_vld_out),
    .soft_reset(d2_soft_reset), .addr_err(d2_addr_err)
  );

  typedef struct {
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int id);
    case (id)
      0:       return 32'(write_enb);
      1:       return 32'(fifo_full);
      2:       return 32'(vld_out);
      3:       return 32'(soft_reset);
      4:       return 32'(addr_err);
      10:      return 32'(d2_write_enb);
      13:      return 32'(d2_soft_reset);
      14:      return 32'(d2_addr_err);
      default: return 32'hdead_beef;
    endcase
  endfunction

  function automatic string name_of(input int id);
    case (id)
      0:       return "write_enb";
      1:       return "fifo_full";
      2:       return "vld_out";
      3:       return "soft_reset";
      4:       return "addr_err";
      10:      return "d2_write_enb";
      13:      return "d2_soft_reset";
      14:      return "d2_addr_err";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_val(input int id, input logic [31:0] v);
    exp_t e;
    e.id  = id;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({phase, ":", name_of(e.id)}, observe(e.id), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b1;
    read_enb = 3'b000; empty = 3'b111; full = 3'b000;
    d2_resetn = 1'b0; d2_detect_add = 1'b0; d2_data_in = 3'd0; d2_write_enb_reg = 1'b0;
    d2_read_enb = 5'b00000; d2_empty = 5'b11111; d2_full = 5'b00000;
    tick();
    tick();

    phase = "reset";
    expect_val(0, 32'h0); expect_val(1, 32'h0); expect_val(2, 32'h0);
    expect_val(3, 32'h0); expect_val(4, 32'h0);
    expect_val(10, 32'h0); expect_val(13, 32'h0); expect_val(14, 32'h0);
    drain();

    // Address 2 selects channel 2
    resetn = 1'b1; d2_resetn = 1'b1;
    write_enb_reg = 1'b0; detect_add = 1'b1; data_in = 2'd2;
    tick();
    phase = "addr2";
    detect_add = 1'b0; write_enb_reg = 1'b1; #1;
    expect_val(0, 32'h4); expect_val(4, 32'h0); drain();
    full = 3'b100; #1;
    expect_val(1, 32'h1); drain();
    full = 3'b011; #1;
    expect_val(1, 32'h0); drain();

    // New header with write request: old address used until the edge
    phase = "same_cycle";
    detect_add = 1'b1; data_in = 2'd0; #1;
    expect_val(0, 32'h4); drain();
    tick();
    detect_add = 1'b0; #1;
    expect_val(0, 32'h1); drain();

    // Out-of-range address, then recovery to channel 1
    phase = "addr_err";
    detect_add = 1'b1; data_in = 2'd3;
    tick();
    detect_add = 1'b0; full = 3'b111; #1;
    expect_val(4, 32'h1); expect_val(0, 32'h0); expect_val(1, 32'h0); drain();
    phase = "addr1";
    detect_add = 1'b1; data_in = 2'd1;
    tick();
    detect_add = 1'b0; #1;
    expect_val(4, 32'h0); expect_val(0, 32'h2); expect_val(1, 32'h1); drain();
    full = 3'b000; write_enb_reg = 1'b0;

    // Channel 0 unread: pulse after the 30th edge only
    phase = "timeout0";
    empty = 3'b110;
    for (int k = 1; k <= 31; k++) begin
      tick();
      expect_val(3, (k == 30) ? 32'h1 : 32'h0);
      expect_val(2, 32'h1);
      drain();
    end
    empty = 3'b111;
    tick();

    // Read on the 30th edge suppresses the pulse and restarts the count
    phase = "read_prio";
    empty = 3'b110;
    for (int k = 1; k <= 30; k++) begin
      read_enb = (k == 30) ? 3'b001 : 3'b000;
      tick();
      expect_val(3, 32'h0);
      drain();
    end
    read_enb = 3'b000;
    phase = "after_read";
    for (int k = 1; k <= 30; k++) begin
      tick();
      expect_val(3, (k == 30) ? 32'h1 : 32'h0);
      drain();
    end
    empty = 3'b111;
    tick();

    // Channels 1 and 2 time out together
    phase = "timeout12";
    empty = 3'b001;
    for (int k = 1; k <= 30; k++) begin
      tick();
      expect_val(3, (k == 30) ? 32'h6 : 32'h0);
      drain();
    end
    empty = 3'b111;
    tick();

    // Reset at count 20 abandons the count
    phase = "pre_reset";
    write_enb_reg = 1'b1; empty = 3'b110;
    for (int k = 1; k <= 20; k++) begin
      tick();
      expect_val(0, 32'h2); expect_val(3, 32'h0);
      drain();
    end
    phase = "mid_reset";
    resetn = 1'b0; #1;
    expect_val(0, 32'h0); drain();
    tick();
    expect_val(3, 32'h0); expect_val(4, 32'h0); expect_val(0, 32'h0); drain();
    resetn = 1'b1; #1;
    phase = "post_reset";
    expect_val(0, 32'h1); drain();
    for (int k = 1; k <= 30; k++) begin
      tick();
      expect_val(3, (k == 30) ? 32'h1 : 32'h0);
      expect_val(0, (k == 30) ? 32'h0 : 32'h1);
      drain();
    end
    empty = 3'b111; write_enb_reg = 1'b0;
    tick();

    // Five-channel instance with short timeout
    phase = "d2_addr4";
    d2_detect_add = 1'b1; d2_data_in = 3'd4;
    tick();
    d2_detect_add = 1'b0; d2_write_enb_reg = 1'b1; #1;
    expect_val(10, 32'h10); expect_val(14, 32'h0); drain();
    phase = "d2_timeout";
    d2_empty = 5'b01111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_val(13, (k == 4) ? 32'h10 : 32'h0);
      expect_val(10, (k == 4) ? 32'h0 : 32'h10);
      drain();
    end
    d2_empty = 5'b11111;
    phase = "d2_addr6";
    d2_detect_add = 1'b1; d2_data_in = 3'd6;
    tick();
    d2_detect_add = 1'b0; #1;
    expect_val(14, 32'h1); expect_val(10, 32'h0); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
